adder_selftest_checker: RTL and testbench
=========================================

# adder_selftest_checker

Synthesizable on-board self-test engine for the lab adder blocks (`halfAdder` at `WIDTH=1`, wider ripple adders at larger `WIDTH`).
- Drives every operand pair into the adder under test.
- Waits a programmable settle time, then compares the adder's sum and carry against an internal reference.
- Reports pass/fail, the error count and the first failing vector on board LEDs.
- It is the consuming end of the adder interface: it drives the adder's inputs and checks its outputs in hardware, where the simulation testbench only drives stimulus.

## Interface
- `WIDTH`, 1, operand width in bits of the adder under test.
- `SETTLE`, 2, clock cycles operands are held before the response is checked (≥1).

Ports (name, direction, width, meaning):
- `clk` input 1 — system clock, rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `start` input 1 — begin a run; sampled only in IDLE or DONE.
- `dut_a` output WIDTH — operand A to the adder under test.
- `dut_b` output WIDTH — operand B to the adder under test.
- `dut_sum` input WIDTH — sum returned by the adder under test.
- `dut_cout` input 1 — carry returned by the adder under test.
- `busy` output 1 — run in progress.
- `done` output 1 — run complete; held until restart or reset.
- `pass` output 1 — `done` and zero mismatches.
- `err_count` output 2*WIDTH+1 — mismatching vectors in the current or last run.
- `fail_a` output WIDTH — A of the first mismatching vector.
- `fail_b` output WIDTH — B of the first mismatching vector.

## Operation
- One clock; `rst` is asynchronous and active-high.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE: `start`=1 → clear vector counter, `err_count`, `fail_a`/`fail_b`; go to DRIVE.
- DRIVE: hold the current vector for SETTLE cycles, counted by a settle counter; then go to CHECK.
- CHECK (1 cycle): compare `{dut_cout,dut_sum}` against `{1'b0,dut_a}+{1'b0,dut_b}` (WIDTH+1-bit reference).
  - On mismatch: increment `err_count`. If `err_count` was 0, capture `dut_a`/`dut_b` into `fail_a`/`fail_b`.
  - If this is the last vector (counter all ones): go to DONE.
  - Otherwise: increment the counter, go to DRIVE.
- Vector counter is 2*WIDTH bits: `dut_a` = upper half, `dut_b` = lower half. Order is (0,0), (0,1), …, (max,max); no wrap-around within a run.
- `err_count` cannot overflow (maximum 2^(2*WIDTH)); no saturation logic.
- DONE: `done`=1, `pass`=(`err_count`==0). `start`=1 → clear and restart exactly as from IDLE.
- `start` in DRIVE or CHECK is ignored.
- `busy`=1 in DRIVE and CHECK only.
- `dut_a`/`dut_b` are registered outputs driven from the vector counter. They hold their last value in DONE.

## Timing
- Reset values: state IDLE, `dut_a`=0, `dut_b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_a`=0, `fail_b`=0.
- `rst` asserted mid-run: all of the above apply immediately (asynchronous); the run is abandoned.
- Edge E samples `start`=1 → after E: `busy`=1, vector (0,0) on `dut_a`/`dut_b`.
- Each vector occupies SETTLE+1 cycles. The adder is combinational, so the response is valid well before the CHECK cycle.
- `done` rises 2^(2*WIDTH)·(SETTLE+1)+1 cycles after edge E; `busy` falls on the same edge.
- `err_count`, `fail_a`, `fail_b` update on the edge that ends a CHECK cycle.
- `pass` and `done` change on the same edge.

## Configuration
- `STOP_ON_FAIL_EN` defined:
  - The first mismatch in CHECK sends the FSM to DONE instead of continuing.
  - `err_count` then ends at 1 and `pass`=0.
  - `dut_a`/`dut_b` remain on the failing vector for probing.
- `STOP_ON_FAIL_EN` undefined: all vectors are always run, and `err_count` is the full mismatch total.

## Test plan
- `WIDTH`=1, `SETTLE`=2, correct `halfAdder`; pulse `start` → `done`=1 after 13 cycles, `pass`=1, `err_count`=0. Vectors seen in order 00, 01, 10, 11.
- `WIDTH`=1, `dut_cout` tied 0 → `done` after 13 cycles, `err_count`=1, `fail_a`=1, `fail_b`=1, `pass`=0.
- `WIDTH`=1, sum and carry swapped → `err_count`=3, `fail_a`=0, `fail_b`=1.
  - With `STOP_ON_FAIL_EN`: `done` after 7 cycles, `err_count`=1, `dut_a`=0, `dut_b`=1.
- `WIDTH`=2, `SETTLE`=2, correct 2-bit adder → `done` after 49 cycles, `pass`=1.
  - Then pulse `start` again → `done` drops on the next edge and the run repeats identically.
- Assert `rst` during vector (1,0), then release and pulse `start` → all outputs 0 immediately on reset; the new run starts from (0,0).
  - `start` pulses during `busy` have no effect on the vector sequence or the completion time.

Source files
------------

// File: rtl/adder_selftest_checker_if.sv
// Operand/response bus between the self-test checker (master) and the adder under test (slave).
interface adder_selftest_checker_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;

  modport master (output dut_a, output dut_b, input dut_sum, input dut_cout);
  modport slave  (input dut_a, input dut_b, output dut_sum, output dut_cout);
endinterface

// File: rtl/adder_selftest_checker.sv
// Exhaustive on-board self-test engine for a WIDTH-bit adder with carry-out.
// Optional build macro STOP_ON_FAIL_EN: halt the run on the first mismatching vector.
//
// state | meaning
// IDLE  | waiting for start after reset
// DRIVE | holding the current vector on dut_a/dut_b while the adder settles
// CHECK | one-cycle compare of {dut_cout,dut_sum} against the reference sum
// DONE  | run finished; results held until restart or reset
module adder_selftest_checker #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  adder_selftest_checker_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [2*WIDTH:0]       err_count,
  output logic [WIDTH-1:0]       fail_a,
  output logic [WIDTH-1:0]       fail_b
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_FIRST = SW'(SETTLE);
  localparam logic [SW-1:0] SETTLE_NEXT  = SW'(SETTLE - 1);

  logic [1:0]         state;
  logic [2*WIDTH-1:0] vec;
  logic [SW-1:0]      settle_cnt;
  logic [WIDTH:0]     ref_sum;
  logic               mismatch;
  logic               last_vec;
  logic               stop_hit;

  assign bus.dut_a = vec[2*WIDTH-1:WIDTH];
  assign bus.dut_b = vec[WIDTH-1:0];

  assign ref_sum  = {1'b0, vec[2*WIDTH-1:WIDTH]} + {1'b0, vec[WIDTH-1:0]};
  assign mismatch = ({bus.dut_cout, bus.dut_sum} != ref_sum);
  assign last_vec = &vec;

`ifdef STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_DRIVE;
            vec        <= '0;
            // The first vector gets one extra settle cycle: the operands only
            // leave their previous (held) value on the start edge itself.
            settle_cnt <= SETTLE_FIRST;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
          end
        end
        S_DRIVE: begin
          if (settle_cnt == '0) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) begin
              fail_a <= vec[2*WIDTH-1:WIDTH];
              fail_b <= vec[WIDTH-1:0];
            end
          end
          if (last_vec || stop_hit) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            state      <= S_DRIVE;
            vec        <= vec + 1'b1;
            settle_cnt <= SETTLE_NEXT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_selftest_checker.sv
// Randomized self-checking bench: two checker instances (WIDTH 1 and 2) against a faultable adder model.
module tb_adder_selftest_checker;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst;
  logic start1, start2;
  logic busy1, done1, pass1;
  logic [2:0] err1;
  logic fa1, fb1;
  logic busy2, done2, pass2;
  logic [4:0] err2;
  logic [1:0] fa2, fb2;

  int tests = 0;
  int fails = 0;
  int mode1 = 0;
  int mode2 = 0;
  logic [1:0] mask1 [4];
  logic [2:0] mask2 [16];

  adder_selftest_checker_if #(.WIDTH(1)) if1 ();
  adder_selftest_checker_if #(.WIDTH(2)) if2 ();

  adder_selftest_checker #(.WIDTH(1), .SETTLE(S)) u1 (
    .clk(clk), .rst(rst), .start(start1), .bus(if1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_a(fa1), .fail_b(fb1)
  );

  adder_selftest_checker #(.WIDTH(2), .SETTLE(S)) u2 (
    .clk(clk), .rst(rst), .start(start2), .bus(if2.master),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_a(fa2), .fail_b(fb2)
  );

  always #5 clk = ~clk;

  // Adder under test: 0 correct, 1 carry tied low, 2 sum/carry swapped (W=1), 3 random bit faults.
  function automatic logic [31:0] resp(input int w, input int mode, input int a, input int b, input int mask);
    logic [31:0] s;
    s = 32'(a + b);
    case (mode)
      1: s[w] = 1'b0;
      2: s = {30'b0, s[0], s[1]};
      3: s = s ^ 32'(mask);
      default: ;
    endcase
    return s;
  endfunction

  logic [31:0] r1, r2;
  always_comb begin
    r1 = resp(1, mode1, int'(if1.dut_a), int'(if1.dut_b), int'(mask1[{if1.dut_a, if1.dut_b}]));
    r2 = resp(2, mode2, int'(if2.dut_a), int'(if2.dut_b), int'(mask2[{if2.dut_a, if2.dut_b}]));
    {if1.dut_cout, if1.dut_sum} = r1[1:0];
    {if2.dut_cout, if2.dut_sum} = r2[2:0];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start1 = v; else start2 = v;
  endtask

  task automatic sample(input int sel, output int busy, output int done, output int pass,
                        output int err, output int a, output int b, output int fa, output int fb);
    if (sel == 1) begin
      busy = int'(busy1); done = int'(done1); pass = int'(pass1); err = int'(err1);
      a = int'(if1.dut_a); b = int'(if1.dut_b); fa = int'(fa1); fb = int'(fb1);
    end else begin
      busy = int'(busy2); done = int'(done2); pass = int'(pass2); err = int'(err2);
      a = int'(if2.dut_a); b = int'(if2.dut_b); fa = int'(fa2); fb = int'(fb2);
    end
  endtask

  task automatic check_cleared(input int sel, input string tag);
    int o_busy, o_done, o_pass, o_err, o_a, o_b, o_fa, o_fb;
    sample(sel, o_busy, o_done, o_pass, o_err, o_a, o_b, o_fa, o_fb);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_pass"}, o_pass, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_vec"}, (o_a << sel) | o_b, 0);
    chk({tag, "_fail"}, (o_fa << sel) | o_fb, 0);
  endtask

  task automatic run(input int sel, input int mode);
    int w, nvec, first, exp_err, n_run, exp_cycles, exp_last, budget;
    int cycles, last_idx, idx;
    int o_busy, o_done, o_pass, o_err, o_a, o_b, o_fa, o_fb;
    w = sel;
    nvec = 1 << (2 * w);
    exp_err = 0;
    first = -1;
    n_run = nvec;
    for (int v = 0; v < nvec; v++) begin
      int a, b, m, r;
      a = v >> w;
      b = v & ((1 << w) - 1);
      m = (sel == 1) ? int'(mask1[v[1:0]]) : int'(mask2[v[3:0]]);
      r = int'(resp(w, mode, a, b, m));
      if (r != a + b) begin
        exp_err++;
        if (first < 0) first = v;
`ifdef STOP_ON_FAIL_EN
        n_run = v + 1;
        break;
`endif
      end
    end
    exp_cycles = n_run * (S + 1) + 1;
    exp_last = n_run - 1;
    budget = exp_cycles + 20;

    @(negedge clk);
    if (sel == 1) mode1 = mode; else mode2 = mode;
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    sample(sel, o_busy, o_done, o_pass, o_err, o_a, o_b, o_fa, o_fb);
    chk($sformatf("w%0d_m%0d_start_busy", w, mode), o_busy, 1);
    chk($sformatf("w%0d_m%0d_start_done", w, mode), o_done, 0);
    chk($sformatf("w%0d_m%0d_start_vec", w, mode), (o_a << w) | o_b, 0);

    cycles = 0;
    last_idx = 0;
    while (cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      sample(sel, o_busy, o_done, o_pass, o_err, o_a, o_b, o_fa, o_fb);
      if (o_done != 0) break;
      idx = (o_a << w) | o_b;
      if (idx != last_idx) begin
        chk($sformatf("w%0d_m%0d_order", w, mode), idx, last_idx + 1);
        last_idx = idx;
      end
      // stray start pulses while busy must be ignored
      set_start(sel, ($urandom_range(0, 3) == 0));
    end
    set_start(sel, 1'b0);

    chk($sformatf("w%0d_m%0d_cycles", w, mode), cycles, exp_cycles);
    chk($sformatf("w%0d_m%0d_done", w, mode), o_done, 1);
    chk($sformatf("w%0d_m%0d_busy", w, mode), o_busy, 0);
    chk($sformatf("w%0d_m%0d_pass", w, mode), o_pass, (exp_err == 0) ? 1 : 0);
`ifdef STOP_ON_FAIL_EN
    chk($sformatf("w%0d_m%0d_err", w, mode), o_err, (exp_err == 0) ? 0 : 1);
`else
    chk($sformatf("w%0d_m%0d_err", w, mode), o_err, exp_err);
`endif
    chk($sformatf("w%0d_m%0d_fail_vec", w, mode), (o_fa << w) | o_fb, (first < 0) ? 0 : first);
    chk($sformatf("w%0d_m%0d_last_vec", w, mode), (o_a << w) | o_b, exp_last);
    repeat (2) @(posedge clk);
    #1;
    sample(sel, o_busy, o_done, o_pass, o_err, o_a, o_b, o_fa, o_fb);
    chk($sformatf("w%0d_m%0d_done_held", w, mode), o_done, 1);
  endtask

  initial begin
    int o_busy, o_done, o_pass, o_err, o_a, o_b, o_fa, o_fb;
    int waited;
    rst = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    for (int v = 0; v < 4; v++) mask1[v] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    for (int v = 0; v < 16; v++) mask2[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;

    repeat (3) @(posedge clk);
    #1;
    check_cleared(1, "reset1");
    check_cleared(2, "reset2");
    @(negedge clk);
    rst = 1'b0;

    run(1, 0);
    run(1, 1);
    run(1, 2);
    run(1, 3);
    run(2, 0);
    run(2, 0);
    run(2, 3);

    // abandon a run on instance 1 at vector (1,0) with an asynchronous reset
    @(negedge clk);
    mode1 = 1;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    waited = 0;
    sample(1, o_busy, o_done, o_pass, o_err, o_a, o_b, o_fa, o_fb);
    while (!(o_a == 1 && o_b == 0) && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
      sample(1, o_busy, o_done, o_pass, o_err, o_a, o_b, o_fa, o_fb);
    end
    chk("reach_vec_10", (o_a == 1 && o_b == 0) ? 1 : 0, 1);
    chk("busy_before_rst", o_busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_cleared(1, "midrun_rst1");
    check_cleared(2, "midrun_rst2");
    @(negedge clk);
    rst = 1'b0;
    run(1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
